// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for the SRAM arbiter: video read port, CPU
// read/write port and boot loader write port. The arbiter uses the
// slave modport; the requesters (or a bench) use the master modport.
interface ram_arbiter_if #(
    parameter int AW = 21
);
    logic          vReq;
    logic [AW-1:0] vA;
    logic [7:0]    vQ;
    logic          vAck;

    logic          cReq;
    logic          cWe;
    logic [AW-1:0] cA;
    logic [7:0]    cD;
    logic [7:0]    cQ;
    logic          cAck;

    logic          lReq;
    logic [AW-1:0] lA;
    logic [7:0]    lD;
    logic          lAck;

    modport slave (
        input  vReq, vA, cReq, cWe, cA, cD, lReq, lA, lD,
        output vQ, vAck, cQ, cAck, lAck
    );

    modport master (
        output vReq, vA, cReq, cWe, cA, cD, lReq, lA, lD,
        input  vQ, vAck, cQ, cAck, lAck
    );
endinterface

// File: rtl/ram_arbiter.sv
// Three-way arbiter in front of a single 8-bit asynchronous SRAM.
// Reads take RD_A/RD_S, writes take WR_A/WR_P/WR_H; completion is
// acked in the following IDLE cycle, which also re-arbitrates. A one-bit
// "owed" token guarantees a pending CPU/loader request is served after
// at most one video access. All pin drivers are registers with async
// reset, so an abort releases ramWe and ramDQ without a clock edge.
module ram_arbiter #(
    parameter int AW = 21
) (
    input  logic          clock,
    input  logic          reset,
    ram_arbiter_if.slave  bus,
    output logic          ramWe,
    inout  wire  [7:0]    ramDQ,
    output logic [AW-1:0] ramA
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_S = 3'd2,
        S_WR_A = 3'd3,
        S_WR_P = 3'd4,
        S_WR_H = 3'd5
    } state_t;

    localparam logic [1:0] ID_V = 2'd0;
    localparam logic [1:0] ID_C = 2'd1;
    localparam logic [1:0] ID_L = 2'd2;

    state_t        r_state;
    logic          r_owed;
    logic [1:0]    r_id;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;
    logic          r_ram_we;
    logic          r_dq_oe;
    logic [7:0]    r_vq;
    logic [7:0]    r_cq;
    logic          r_v_ack;
    logic          r_c_ack;
    logic          r_l_ack;

    logic          w_v_eff;
    logic          w_c_eff;
    logic          w_l_eff;
    logic          w_nv_pend;
    logic [1:0]    w_nv_id;
    logic          w_nv_we;
    logic [AW-1:0] w_nv_a;
    logic [7:0]    w_nv_d;

    state_t        w_state_nxt;
    logic          w_owed_nxt;
    logic          w_grant;
    logic [1:0]    w_gnt_id;
    logic          w_gnt_we;
    logic [AW-1:0] w_gnt_a;
    logic [7:0]    w_gnt_d;
    logic          w_done;
    logic          w_wr_nxt;

    assign ramA     = r_addr;
    assign ramWe    = r_ram_we;
    assign ramDQ    = r_dq_oe ? r_wdata : 8'hzz;
    assign bus.vQ   = r_vq;
    assign bus.cQ   = r_cq;
    assign bus.vAck = r_v_ack;
    assign bus.cAck = r_c_ack;
    assign bus.lAck = r_l_ack;

    // Effective requests (the one being acked is masked) and non-video winner.
    always_comb begin
        w_v_eff   = bus.vReq & ~r_v_ack;
        w_c_eff   = bus.cReq & ~r_c_ack;
        w_l_eff   = bus.lReq & ~r_l_ack;
        w_nv_pend = w_l_eff | w_c_eff;
        if (w_l_eff) begin
            w_nv_id = ID_L;
            w_nv_we = 1'b1;
            w_nv_a  = bus.lA;
            w_nv_d  = bus.lD;
        end else begin
            w_nv_id = ID_C;
            w_nv_we = bus.cWe;
            w_nv_a  = bus.cA;
            w_nv_d  = bus.cD;
        end
    end

    // Next-state, fairness token and grant selection.
    always_comb begin
        w_state_nxt = r_state;
        w_owed_nxt  = r_owed;
        w_grant     = 1'b0;
        w_gnt_id    = ID_V;
        w_gnt_we    = 1'b0;
        w_gnt_a     = bus.vA;
        w_gnt_d     = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_v_eff && !(r_owed && w_nv_pend)) begin
                    w_grant    = 1'b1;
                    w_owed_nxt = w_nv_pend ? 1'b1 : r_owed;
                end else if (w_nv_pend) begin
                    w_grant    = 1'b1;
                    w_gnt_id   = w_nv_id;
                    w_gnt_we   = w_nv_we;
                    w_gnt_a    = w_nv_a;
                    w_gnt_d    = w_nv_d;
                    w_owed_nxt = 1'b0;
                end else begin
                    w_grant = 1'b0;
                end
                if (w_grant) begin
                    w_state_nxt = w_gnt_we ? S_WR_A : S_RD_A;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_A:  w_state_nxt = S_RD_S;
            S_RD_S:  w_state_nxt = S_IDLE;
            S_WR_A:  w_state_nxt = S_WR_P;
            S_WR_P:  w_state_nxt = S_WR_H;
            S_WR_H:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        w_done   = (r_state == S_RD_S) || (r_state == S_WR_H);
        w_wr_nxt = (w_state_nxt == S_WR_A) || (w_state_nxt == S_WR_P) ||
                   (w_state_nxt == S_WR_H);
    end

    // State, latched transaction, pin drivers, read data and ack strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_owed   <= 1'b0;
            r_id     <= ID_V;
            r_addr   <= {AW{1'b0}};
            r_wdata  <= 8'h00;
            r_ram_we <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_vq     <= 8'h00;
            r_cq     <= 8'h00;
            r_v_ack  <= 1'b0;
            r_c_ack  <= 1'b0;
            r_l_ack  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owed   <= w_owed_nxt;
            if (w_grant) begin
                r_id    <= w_gnt_id;
                r_addr  <= w_gnt_a;
                r_wdata <= w_gnt_d;
            end
            r_ram_we <= (w_state_nxt != S_WR_P);
            r_dq_oe  <= w_wr_nxt;
            if ((r_state == S_RD_S) && (r_id == ID_V)) begin
                r_vq <= ramDQ;
            end
            if ((r_state == S_RD_S) && (r_id == ID_C)) begin
                r_cq <= ramDQ;
            end
            r_v_ack <= w_done && (r_id == ID_V);
            r_c_ack <= w_done && (r_id == ID_C);
            r_l_ack <= w_done && (r_id == ID_L);
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a small SRAM model on the pins.
// The data bus is pulled up, so an undriven bus reads as 8'hFF.
module tb_ram_arbiter;
    localparam int AW = 21;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          ram_we;
    wire  [7:0]    ram_dq;
    logic [AW-1:0] ram_a;
    logic          rd_en = 1'b0;
    logic [7:0]    mem [0:255];
    int            n_checks = 0;
    int            n_errors = 0;

    ram_arbiter_if #(.AW(AW)) bus ();

    ram_arbiter #(.AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .ramWe (ram_we),
        .ramDQ (ram_dq),
        .ramA  (ram_a)
    );

    always #5 clock = ~clock;

    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (ram_dq[g]);
    end

    assign ram_dq = rd_en ? mem[ram_a[7:0]] : 8'hzz;

    always @(posedge ram_we) begin
        if (reset) mem[ram_a[7:0]] = ram_dq;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_reqs();
        bus.vReq = 1'b0; bus.cReq = 1'b0; bus.lReq = 1'b0; bus.cWe = 1'b0;
    endtask

    task automatic test_reset();
        bus.vReq = 1'b1; bus.vA = 21'h00055;
        bus.cReq = 1'b1; bus.cWe = 1'b0; bus.cA = 21'h00066; bus.cD = 8'h11;
        bus.lReq = 1'b1; bus.lA = 21'h00077; bus.lD = 8'h22;
        reset = 1'b0;
        tick(); tick();
        n_checks++;
        if (ram_we !== 1'b1 || ram_dq !== 8'hFF || ram_a !== 21'h0) begin
            n_errors++;
            $display("FAIL reset_pins: we=%b dq=%h a=%h want we=1 dq=ff a=0", ram_we, ram_dq, ram_a);
        end
        n_checks++;
        if ({bus.vAck, bus.cAck, bus.lAck} !== 3'b000 || bus.vQ !== 8'h00 || bus.cQ !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_acks: acks=%b vQ=%h cQ=%h want 000/00/00",
                     {bus.vAck, bus.cAck, bus.lAck}, bus.vQ, bus.cQ);
        end
        #3 reset = 1'b1;
        tick();
        n_checks++;
        if (ram_a !== 21'h00055 || ram_we !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_first_grant: a=%h we=%b want a=00055 we=1", ram_a, ram_we);
        end
        clear_reqs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_cpu_write_read();
        logic [3:0] exp_we;
        logic [3:0] exp_ack;
        exp_we  = 4'b1101;
        exp_ack = 4'b1000;
        bus.cReq = 1'b1; bus.cWe = 1'b1; bus.cA = 21'h01234; bus.cD = 8'hA5;
        for (int t = 0; t < 4; t++) begin
            tick();
            n_checks++;
            if (ram_we !== exp_we[t] || bus.cAck !== exp_ack[t]) begin
                n_errors++;
                $display("FAIL cpu_write_t%0d: we=%b ack=%b want we=%b ack=%b",
                         t + 1, ram_we, bus.cAck, exp_we[t], exp_ack[t]);
            end
            if (t < 3) begin
                n_checks++;
                if (ram_a !== 21'h01234 || ram_dq !== 8'hA5) begin
                    n_errors++;
                    $display("FAIL cpu_write_bus_t%0d: a=%h dq=%h want 01234/a5", t + 1, ram_a, ram_dq);
                end
            end
        end
        n_checks++;
        if (ram_dq !== 8'hFF) begin
            n_errors++;
            $display("FAIL cpu_write_release: dq=%h want ff", ram_dq);
        end
        bus.cReq = 1'b0;
        tick();
        bus.cReq = 1'b1; bus.cWe = 1'b0; rd_en = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_checks++;
            if (bus.cAck !== (t == 2)) begin
                n_errors++;
                $display("FAIL cpu_read_ack_t%0d: ack=%b want %b", t + 1, bus.cAck, (t == 2));
            end
        end
        n_checks++;
        if (bus.cQ !== 8'hA5) begin
            n_errors++;
            $display("FAIL cpu_read_data: cQ=%h want a5", bus.cQ);
        end
        bus.cReq = 1'b0; rd_en = 1'b0;
        tick();
    endtask

    task automatic test_fairness();
        int   seq [4];
        int   exp_seq [4];
        int   n_ack;
        int   c_wait;
        int   n_vack;
        logic [7:0] exp_vq;
        exp_seq = '{0, 1, 0, 1};
        n_ack = 0; c_wait = -1; n_vack = 0; exp_vq = 8'h00;
        bus.vReq = 1'b1; bus.vA = 21'h00010; rd_en = 1'b1;
        tick();
        bus.cReq = 1'b1; bus.cWe = 1'b0; bus.cA = 21'h00020;
        for (int t = 1; t <= 20 && n_ack < 4; t++) begin
            tick();
            if (bus.vAck === 1'b1) begin
                seq[n_ack] = 0; n_ack++;
                exp_vq = (n_vack == 0) ? 8'h3C : 8'h5A;
                n_vack++;
                n_checks++;
                if (bus.vQ !== exp_vq) begin
                    n_errors++;
                    $display("FAIL fair_vq: vQ=%h want %h", bus.vQ, exp_vq);
                end
                bus.vA = 21'h00011;
            end
            if (bus.cAck === 1'b1) begin
                seq[n_ack] = 1; n_ack++;
                if (c_wait < 0) c_wait = t;
                n_checks++;
                if (bus.cQ !== 8'hC3 || bus.vQ !== exp_vq) begin
                    n_errors++;
                    $display("FAIL fair_cq_vhold: cQ=%h vQ=%h want c3 %h", bus.cQ, bus.vQ, exp_vq);
                end
            end
            if (n_ack == 4) clear_reqs();
        end
        clear_reqs();
        rd_en = 1'b0;
        n_checks++;
        if (n_ack != 4) begin
            n_errors++;
            $display("FAIL fair_timeout: acks=%0d want 4", n_ack);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (seq[i] != exp_seq[i]) begin
                    n_errors++;
                    $display("FAIL fair_seq%0d: got %0d want %0d (0=V 1=C)", i, seq[i], exp_seq[i]);
                end
            end
        end
        n_checks++;
        if (c_wait < 0 || c_wait > 8) begin
            n_errors++;
            $display("FAIL fair_cwait: cAck %0d clocks after cReq want 1..8", c_wait);
        end
        tick(); tick();
    endtask

    task automatic test_loader_vs_cpu();
        int l_t;
        int c_t;
        logic [2:0] exp_we;
        exp_we = 3'b101;
        l_t = -1; c_t = -1;
        bus.lReq = 1'b1; bus.lA = 21'h00040; bus.lD = 8'h77;
        bus.cReq = 1'b1; bus.cWe = 1'b0; bus.cA = 21'h00040;
        for (int t = 1; t <= 12 && c_t < 0; t++) begin
            tick();
            if (t <= 3) begin
                n_checks++;
                if (ram_we !== exp_we[t-1] || ram_a !== 21'h00040 || ram_dq !== 8'h77) begin
                    n_errors++;
                    $display("FAIL ld_write_t%0d: we=%b a=%h dq=%h want %b 00040 77",
                             t, ram_we, ram_a, ram_dq, exp_we[t-1]);
                end
            end
            if (bus.lAck === 1'b1) begin
                l_t = t; bus.lReq = 1'b0; rd_en = 1'b1;
            end
            if (bus.cAck === 1'b1) begin
                c_t = t; bus.cReq = 1'b0;
            end
        end
        clear_reqs();
        rd_en = 1'b0;
        n_checks++;
        if (l_t != 4) begin
            n_errors++;
            $display("FAIL ld_ack_time: lAck at %0d want 4", l_t);
        end
        // CPU is granted in the lAck cycle, so the gap is the read latency.
        n_checks++;
        if (c_t - l_t != 3 || l_t < 0) begin
            n_errors++;
            $display("FAIL ld_cpu_gap: cAck-lAck=%0d want 3", c_t - l_t);
        end
        n_checks++;
        if (bus.cQ !== 8'h77) begin
            n_errors++;
            $display("FAIL ld_cpu_data: cQ=%h want 77", bus.cQ);
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        bus.cReq = 1'b1; bus.cWe = 1'b1; bus.cA = 21'h00ABC; bus.cD = 8'h3C;
        tick(); tick();
        n_checks++;
        if (ram_we !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_pre: we=%b want 0", ram_we);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (ram_we !== 1'b1 || ram_dq !== 8'hFF) begin
            n_errors++;
            $display("FAIL abort_async: we=%b dq=%h want 1 ff", ram_we, ram_dq);
        end
        bus.cReq = 1'b0;
        tick();
        reset = 1'b1;
        for (int t = 0; t < 5; t++) begin
            tick();
            n_checks++;
            if ({bus.vAck, bus.cAck, bus.lAck} !== 3'b000 || ram_we !== 1'b1) begin
                n_errors++;
                $display("FAIL abort_noack_t%0d: acks=%b we=%b want 000 1",
                         t, {bus.vAck, bus.cAck, bus.lAck}, ram_we);
            end
        end
        bus.cReq = 1'b1; bus.cWe = 1'b0; bus.cA = 21'h00099; rd_en = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_checks++;
            if (bus.cAck !== (t == 3)) begin
                n_errors++;
                $display("FAIL abort_idle_read_t%0d: ack=%b want %b", t, bus.cAck, (t == 3));
            end
        end
        n_checks++;
        if (bus.cQ !== 8'h6E) begin
            n_errors++;
            $display("FAIL abort_idle_data: cQ=%h want 6e", bus.cQ);
        end
        clear_reqs();
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_idle_bus();
        for (int t = 0; t < 100; t++) begin
            tick();
            n_checks++;
            if (ram_dq !== 8'hFF || ram_we !== 1'b1 || {bus.vAck, bus.cAck, bus.lAck} !== 3'b000) begin
                n_errors++;
                $display("FAIL idle_t%0d: dq=%h we=%b acks=%b want ff 1 000",
                         t, ram_dq, ram_we, {bus.vAck, bus.cAck, bus.lAck});
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h3C;
        mem[8'h11] = 8'h5A;
        mem[8'h20] = 8'hC3;
        mem[8'h99] = 8'h6E;
        bus.vA = '0; bus.cA = '0; bus.lA = '0; bus.cD = 8'h00; bus.lD = 8'h00;
        clear_reqs();
        test_reset();
        test_cpu_write_read();
        test_fairness();
        test_loader_vs_cpu();
        test_reset_mid_write();
        test_idle_bus();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
